// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-driver-side signals of spi_arbiter, bundled for port connection.
// The slave modport is the arbiter's view; master is the environment (requesters plus driver).
interface spi_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    done;
  logic [15:0]           rsp_data;
  logic                  rsp_valid;
  logic [2:0]            rsp_id;
  logic                  rsp_err;
  logic [15:0]           spi_pdi;
  logic                  spi_send;
  logic [15:0]           spi_pdo;
  logic                  spi_data_valid;
  logic                  spi_cs;

  modport slave (
    input  req, req_data, spi_pdo, spi_data_valid, spi_cs,
    output done, rsp_data, rsp_valid, rsp_id, rsp_err, spi_pdi, spi_send
  );

  modport master (
    output req, req_data, spi_pdo, spi_data_valid, spi_cs,
    input  done, rsp_data, rsp_valid, rsp_id, rsp_err, spi_pdi, spi_send
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI driver among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to abort LAUNCH/BUSY waits after TIMEOUT cycles with rsp_err.
module spi_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic          sclk,
  input logic          reset_n,
  spi_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  localparam logic [3:0] LP_N = 4'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT < 8 || TIMEOUT > 255) begin : g_bad_timeout
    $error("spi_arbiter: TIMEOUT must be 8..255");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_cur_id;
  logic [15:0]          r_pdi;
  logic                 r_send;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_rsp_valid;
  logic [15:0]          r_rsp_data;
  logic [2:0]           r_rsp_id;
  logic                 r_rsp_err;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [2:0]           w_off;
  logic [3:0]           w_sum;
  logic [3:0]           w_ptr_inc;
  logic [2:0]           w_grant_id;
  logic [2:0]           w_ptr_nxt;
  logic                 w_grant_vld;
  logic [15:0]          w_sel_data;
  logic                 w_frame_end;
  logic                 w_timeout;
  logic                 w_abort;

  // Rotate req so bit 0 is the requester at rr_ptr; the lowest set bit is the grant.
  assign w_req_dbl = {bus.req, bus.req};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = 3'(k);
    end
  end

  assign w_grant_vld = |bus.req;
  assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_grant_id  = (w_sum >= LP_N) ? 3'(w_sum - LP_N) : w_sum[2:0];
  assign w_ptr_inc   = {1'b0, w_grant_id} + 4'd1;
  assign w_ptr_nxt   = (w_ptr_inc >= LP_N) ? 3'(w_ptr_inc - LP_N) : w_ptr_inc[2:0];

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_id == 3'(k)) w_sel_data = bus.req_data[16*k +: 16];
    end
  end

  // data_valid is already high between frames, so completion also requires cs back high.
  assign w_frame_end = bus.spi_cs && bus.spi_data_valid;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= '0;
    end else if (r_state == LAUNCH || r_state == BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == LAUNCH || r_state == BUSY) && (r_tmo_cnt == LP_TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = LAUNCH;
      LAUNCH:  if (w_timeout) w_state_nxt = DONE;
               else if (!bus.spi_cs) w_state_nxt = BUSY;
      BUSY:    if (w_frame_end || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_abort = !(r_state == BUSY && w_frame_end);

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= '0;
      r_cur_id    <= '0;
      r_pdi       <= '0;
      r_send      <= 1'b0;
      r_done      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_send      <= (w_state_nxt == LAUNCH);
      r_rsp_valid <= (w_state_nxt == DONE);
      r_done      <= '0;
      r_rsp_err   <= 1'b0;
      if (r_state == IDLE && w_grant_vld) begin
        r_pdi    <= w_sel_data;
        r_cur_id <= w_grant_id;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_state_nxt == DONE) begin
        r_done     <= NUM_REQ'(1) << r_cur_id;
        r_rsp_id   <= r_cur_id;
        r_rsp_err  <= w_abort;
        r_rsp_data <= w_abort ? 16'h0000 : bus.spi_pdo;
      end
    end
  end

  assign bus.spi_pdi   = r_pdi;
  assign bus.spi_send  = r_send;
  assign bus.done      = r_done;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural SPI driver, round-robin reference model, queue scoreboard.
module tb_spi_arbiter;
  localparam int N = 4;

  logic sclk    = 1'b0;
  logic reset_n = 1'b1;
  always #5 sclk = ~sclk;

  spi_arbiter_if #(.NUM_REQ(N)) bus ();
  spi_arbiter #(.NUM_REQ(N), .TIMEOUT(64)) dut (.sclk(sclk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] resp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_ptr = 0;
  bit          cs_stuck = 1'b0;
  logic [15:0] words [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req_v);
    end
  endtask

  // SPI driver model: frame starts on a send rising edge, ends 16 cycles later.
  initial begin : drv
    logic        prev_send;
    logic [15:0] cur_resp;
    int          cnt;
    bit          active;
    bus.spi_cs         = 1'b1;
    bus.spi_data_valid = 1'b0;
    bus.spi_pdo        = 16'h0;
    prev_send = 1'b0;
    cur_resp  = 16'h0;
    cnt       = 0;
    active    = 1'b0;
    forever begin
      @(posedge sclk); #1;
      if (active) begin
        cnt++;
        if (cnt == 16) begin
          bus.spi_cs         = 1'b1;
          bus.spi_data_valid = 1'b1;
          bus.spi_pdo        = cur_resp;
          active             = 1'b0;
        end
      end else if (bus.spi_send && !prev_send && !cs_stuck) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL slave_rx: unexpected frame with pdi %0h", bus.spi_pdi);
        end else begin
          check("slave_rx", 32'(bus.spi_pdi), 32'(tx_q.pop_front()));
        end
        cur_resp           = (resp_q.size() != 0) ? resp_q.pop_front() : 16'h0;
        bus.spi_cs         = 1'b0;
        bus.spi_data_valid = 1'b0;
        active             = 1'b1;
        cnt                = 0;
      end
      prev_send = bus.spi_send;
    end
  end

  // Monitor: pops the scoreboard on every rsp_valid, checks done pulses and send spacing.
  initial begin : mon
    exp_t e;
    int   gap;
    logic prev_send;
    gap       = 0;
    prev_send = 1'b0;
    forever begin
      @(negedge sclk);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: id %0d data %0h with nothing pending", bus.rsp_id, bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id",   32'(bus.rsp_id),   32'(e.id));
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check("rsp_err",  32'(bus.rsp_err),  32'(e.err));
          check("done_vec", 32'(bus.done),     32'(1) << e.id);
        end
      end else begin
        check("done_idle", 32'(bus.done), 32'h0);
      end
      if (bus.spi_send && !prev_send) check("send_gap_ge2", 32'(gap >= 2), 32'h1);
      if (bus.spi_send) gap = 0;
      else if (gap < 1000) gap++;
      prev_send = bus.spi_send;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: serve the held set in round-robin order from the model pointer.
  task automatic run_batch(input logic [N-1:0] mask, input bit use_fixed, input logic [15:0] fixed_resp);
    logic [N-1:0] rem;
    int           pick;
    int           id;
    int           budget;
    exp_t         e;
    logic [15:0]  r;
    rem = mask;
    while (rem != '0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        id = (m_ptr + k) % N;
        if (pick < 0 && ((rem >> id) & N'(1)) != '0) pick = id;
      end
      rem   = rem & ~(N'(1) << pick);
      m_ptr = (pick + 1) % N;
      r     = use_fixed ? fixed_resp : 16'($urandom);
      e.id  = pick;
      e.err = cs_stuck;
      e.data = cs_stuck ? 16'h0 : r;
      if (!cs_stuck) begin
        resp_q.push_back(r);
        tx_q.push_back(words[pick]);
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < N; i++) bus.req_data[16*i +: 16] = words[i];
    bus.req = mask;
    budget  = 120 * N;
    while (bus.req != '0 && budget > 0) begin
      @(posedge sclk); #1;
      bus.req = bus.req & ~bus.done;
      budget--;
    end
    if (bus.req != '0) begin
      n_cmp++; n_bad++;
      $display("FAIL batch_timeout: req still %b, required all dropped", bus.req);
      bus.req = '0;
    end
    repeat (2) @(posedge sclk);
    #1;
  endtask

  task automatic rand_words();
    for (int i = 0; i < N; i++) words[i] = 16'($urandom) | 16'h0001;
  endtask

  initial begin : main
    int hi;
    int budget;
    logic [N-1:0] m;
    bus.req      = '0;
    bus.req_data = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1 reset_n = 1'b1;

    check("rst_send",      32'(bus.spi_send),  32'h0);
    check("rst_pdi",       32'(bus.spi_pdi),   32'h0);
    check("rst_done",      32'(bus.done),      32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    hi = 0;
    repeat (100) begin
      @(negedge sclk);
      if (bus.spi_send) hi++;
    end
    check("idle_send_cycles", 32'(hi), 32'h0);
    @(posedge sclk); #1;

    rand_words();
    words[2] = 16'hA5C3;
    run_batch(4'b0100, 1'b1, 16'h1234);

    rand_words();
    run_batch(4'b1000, 1'b0, 16'h0);
    run_batch(4'b1111, 1'b0, 16'h0);
    rand_words();
    run_batch(4'b1111, 1'b0, 16'h0);

    rand_words();
    run_batch(4'b0010, 1'b0, 16'h0);
    run_batch(4'b1010, 1'b0, 16'h0);

    for (int t = 0; t < 25; t++) begin
      rand_words();
      m = N'($urandom_range(1, (1 << N) - 1));
      run_batch(m, 1'b0, 16'h0);
    end

    // Reset while the frame is in flight.
    words[0] = 16'hBEEF;
    bus.req_data[15:0] = 16'hBEEF;
    tx_q.push_back(16'hBEEF);
    resp_q.push_back(16'($urandom));
    bus.req = 4'b0001;
    budget = 20;
    while (budget > 0) begin
      @(posedge sclk); #1;
      if (!bus.spi_cs && !bus.spi_send) break;
      budget--;
    end
    check("busy_reached", 32'(budget > 0), 32'h1);
    reset_n = 1'b0;
    #1;
    check("arst_send",      32'(bus.spi_send),  32'h0);
    check("arst_pdi",       32'(bus.spi_pdi),   32'h0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("arst_rsp_data",  32'(bus.rsp_data),  32'h0);
    check("arst_rsp_id",    32'(bus.rsp_id),    32'h0);
    check("arst_done",      32'(bus.done),      32'h0);
    bus.req = '0;
    m_ptr   = 0;
    repeat (3) @(posedge sclk);
    #1 reset_n = 1'b1;
    budget = 40;
    while (!bus.spi_cs && budget > 0) begin
      @(posedge sclk); #1;
      budget--;
    end
    check("old_frame_end", 32'(bus.spi_cs), 32'h1);
    rand_words();
    run_batch(4'b0001, 1'b0, 16'h0);
    rand_words();
    run_batch(4'b0110, 1'b0, 16'h0);

`ifdef SPI_ARB_TIMEOUT_EN
    cs_stuck = 1'b1;
    rand_words();
    run_batch(4'b0001, 1'b0, 16'h0);
    check("tmo_send_low", 32'(bus.spi_send), 32'h0);
    cs_stuck = 1'b0;
    rand_words();
    run_batch(4'b1001, 1'b0, 16'h0);
`endif

    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge sclk);
      budget--;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one 16-bit SPI driver (`spi_16i_16o`) among up to `NUM_REQ` requesters. Requesters arrive as independent blocks, such as an ADC poller, a DAC writer and a config loader. The block arbitrates round-robin, launches each frame on the driver's `send` edge, tracks completion through the driver's `cs`/`data_valid`, and returns the received word to the granted requester. It sits between the lab datapath and the single SPI driver instance, in the same `sclk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: cycles allowed per wait state before aborting; 8..255.
- `sclk` input 1: system clock; all logic on posedge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `req` input NUM_REQ: request per requester. Held high until its `done` bit pulses.
- `req_data` input 16*NUM_REQ: word to transmit. Requester i occupies bits [16i+15:16i] and holds them stable while `req[i]` is high.
- `done` output NUM_REQ: one-cycle pulse to the serviced requester.
- `rsp_data` output 16: received word, valid with `rsp_valid`.
- `rsp_valid` output 1: one-cycle pulse on completion, successful or aborted.
- `rsp_id` output 3: index of the serviced requester, valid with `rsp_valid`.
- `rsp_err` output 1: high with `rsp_valid` when the frame timed out.
- `spi_pdi` output 16: word to the driver's `pdi`.
- `spi_send` output 1: to the driver's `send`.
- `spi_pdo` input 16: from the driver's `pdo`.
- `spi_data_valid` input 1: from the driver's `data_valid`.
- `spi_cs` input 1: from the driver's `cs`, active-low frame indicator.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- **IDLE**
  - If any `req` is high, grant the first set bit at or after `rr_ptr`, searching upward with wrap at `NUM_REQ`-1 → 0.
  - Latch that requester's `req_data` into `spi_pdi`, latch its index into `cur_id`, set `rr_ptr` = (`cur_id`+1) mod `NUM_REQ`, and go to LAUNCH.
- **LAUNCH**
  - `spi_send`=1.
  - On `spi_cs`==0 (the driver has started the frame): `spi_send`=0 and go to BUSY.
- **BUSY**
  - `spi_send`=0.
  - On `spi_cs`==1 && `spi_data_valid`==1: capture `spi_pdo` into `rsp_data` and go to DONE.
- **DONE**
  - Lasts one cycle: `rsp_valid`=1, `done[cur_id]`=1, `rsp_id`=`cur_id`, `rsp_err` as latched. Then go to IDLE.
- `spi_send` is therefore low for at least 2 cycles (DONE plus IDLE) before the next LAUNCH, which guarantees the driver sees a fresh rising edge.
- `data_valid` alone is never used as a start acknowledge, because it is already 0 before the driver's first frame.
- Grant ordering is round-robin. `rr_ptr` advances only on grant. A requester that drops `req` before being granted is simply skipped.
- `req` sampled high in DONE does not start a frame; arbitration happens only in IDLE.
- Reset mid-frame returns the FSM to IDLE with `spi_send`=0. The driver finishes its frame independently. The next LAUNCH waits for `spi_cs`==0 of a new frame; if the old frame is still running, `spi_cs` is already 0 and the following BUSY completes on the old frame's end. This is an accepted corner case, documented for the integrator.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `cur_id`=0.
  - `spi_send`=0, `spi_pdi`=0.
  - `done`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, `rsp_id`=0.
- All outputs are registered.
- Cycle-level sequence with the 16-bit driver:
  - Cycle 0: IDLE samples `req`.
  - Cycle 1: `spi_send`=1.
  - Cycle 2: driver `cs` falls, seen in LAUNCH.
  - Cycle 3: `spi_send`=0.
  - About 16 cycles later: `cs`/`data_valid` rise.
  - Next cycle: DONE pulses.
- Nominal request-to-`rsp_valid` latency is about 20 cycles. The bench checks the ordering of events, not an exact count.
- Back-to-back requests: at most 1 idle cycle between DONE and the next LAUNCH.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on every state entry and increments in LAUNCH and BUSY.
  - Reaching `TIMEOUT` forces DONE with `rsp_err`=1 and `rsp_data`=16'h0000, and drops `spi_send`.
- Not defined:
  - No counter is built and `rsp_err` is tied 0.
  - LAUNCH and BUSY wait indefinitely.

## Test plan
- Reset with `req`=0 → all outputs at reset values; `spi_send` stays 0 for 100 cycles.
- `req`=4'b0100, `req_data[47:32]`=16'hA5C3, driver model with slave returning 16'h1234 → slave receives 16'hA5C3; `rsp_valid` with `rsp_data`=16'h1234, `rsp_id`=2, `rsp_err`=0; `done`=4'b0100 pulses for one cycle.
- `req`=4'b1111 held, each requester dropping on its own `done` → grant order 0,1,2,3. Then re-raise all four → order again 0,1,2,3 starting at `rr_ptr`=0 after the wrap.
- `req[1]` and `req[3]` both high with `rr_ptr`=2 → requester 3 served first, then 1.
- With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT`=64, driver `cs` stuck high → after 64 cycles in LAUNCH: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, `spi_send`=0, FSM back in IDLE.
- Assert `reset_n` low in BUSY → outputs return to reset values asynchronously; after release, a new request completes normally once the driver's `cs` returns high.
